// File: rtl/rocc_cmd_responder_pkg.sv
// rtl/rocc_cmd_responder_pkg.sv - shared funct codes, response type and error word
package dana_rocc_pkg;

  localparam logic [6:0] FUNCT_SET_ASID   = 7'd0;
  localparam logic [6:0] FUNCT_NEW_TID    = 7'd1;
  localparam logic [6:0] FUNCT_WRITE_DATA = 7'd2;
  localparam logic [6:0] FUNCT_READ_DATA  = 7'd3;
  localparam logic [6:0] FUNCT_CLEAR_INT  = 7'd4;

  // Data word returned for every illegal or failed command
  localparam logic [63:0] RESP_ERROR = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } rocc_resp_t;

endpackage

// File: rtl/rocc_cmd_responder_if.sv
// rtl/rocc_cmd_responder_if.sv - ready/valid channel carrying one RoCC response
interface rocc_cmd_responder_if;
  import dana_rocc_pkg::*;

  logic       valid;
  logic       ready;
  rocc_resp_t bits;

  modport master (output valid, output bits, input ready);
  modport slave  (input valid, input bits, output ready);

endinterface

// File: rtl/rocc_cmd_responder_resp_queue.sv
// rtl/rocc_cmd_responder_resp_queue.sv - registered FIFO of RoCC responses with occupancy count
module rocc_resp_queue
  import dana_rocc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  rocc_cmd_responder_if.slave          enq,
  rocc_cmd_responder_if.master         deq,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rocc_resp_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = enq.valid && !w_full;
  assign w_pop   = !w_empty && deq.ready;

  assign enq.ready = !w_full;
  assign deq.valid = !w_empty;
  // Output is driven straight from storage; zero when nothing is queued
  assign deq.bits  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only observed while the count covers them
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= enq.bits;
  end

endmodule

// File: rtl/rocc_cmd_responder.sv
// rtl/rocc_cmd_responder.sv - RoCC command decode, TID slots, data store and buffered responses
module rocc_cmd_responder
  import dana_rocc_pkg::*;
#(
  parameter int NUM_TIDS   = 4,
  parameter int RESP_DEPTH = 2,
  parameter int ASID_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic [6:0]  io_cmd_bits_inst_funct,
  input  logic [4:0]  io_cmd_bits_inst_rs2,
  input  logic [4:0]  io_cmd_bits_inst_rs1,
  input  logic        io_cmd_bits_inst_xd,
  input  logic        io_cmd_bits_inst_xs1,
  input  logic        io_cmd_bits_inst_xs2,
  input  logic [4:0]  io_cmd_bits_inst_rd,
  input  logic [6:0]  io_cmd_bits_inst_opcode,
  input  logic [63:0] io_cmd_bits_rs1,
  input  logic [63:0] io_cmd_bits_rs2,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [4:0]  io_resp_bits_rd,
  output logic [63:0] io_resp_bits_data,
  output logic        io_busy,
  input  logic        io_s,
  output logic        io_interrupt
);

  localparam int TID_W = (NUM_TIDS > 1) ? $clog2(NUM_TIDS) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [ASID_W-1:0]   r_asid;
  logic [NUM_TIDS-1:0] r_slot_valid;
  logic [63:0]         r_data_store [NUM_TIDS];
  logic                r_interrupt;

  logic             w_accept;
  logic [TID_W-1:0] w_tid;
  logic [TID_W-1:0] w_free_tid;
  logic             w_any_free;
  logic             w_err;
  logic             w_set_asid;
  logic             w_alloc;
  logic             w_write;
  logic             w_read;
  logic             w_clear_int;
  logic [63:0]      w_data;
  logic [CNT_W-1:0] w_count;
  logic             w_unused;

  rocc_cmd_responder_if enq_if ();
  rocc_cmd_responder_if deq_if ();

  rocc_resp_queue #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq     (enq_if.slave),
    .deq     (deq_if.master),
    .o_count (w_count)
  );

  // Acceptance depends only on the registered occupancy, never on a same-cycle dequeue
  assign io_cmd_ready = !reset && enq_if.ready;
  assign w_accept     = io_cmd_valid && io_cmd_ready;
  assign w_tid        = io_cmd_bits_rs1[TID_W-1:0];

  assign enq_if.valid = w_accept && io_cmd_bits_inst_xd;
  assign enq_if.bits  = {io_cmd_bits_inst_rd, w_data};

  assign deq_if.ready      = io_resp_ready;
  assign io_resp_valid     = deq_if.valid;
  assign io_resp_bits_rd   = deq_if.bits.rd;
  assign io_resp_bits_data = deq_if.bits.data;

  assign io_busy      = (w_count != '0);
  assign io_interrupt = r_interrupt;

  // Instruction fields that play no part in decoding
  assign w_unused = ^{io_cmd_bits_inst_rs2, io_cmd_bits_inst_rs1, io_cmd_bits_inst_xs1,
                      io_cmd_bits_inst_xs2, io_cmd_bits_inst_opcode,
                      io_cmd_bits_rs1[63:ASID_W]};

  // Priority allocator: the lowest-numbered free slot wins
  always_comb begin
    w_any_free = 1'b0;
    w_free_tid = '0;
    for (int i = NUM_TIDS - 1; i >= 0; i--) begin
      if (!r_slot_valid[i]) begin
        w_any_free = 1'b1;
        w_free_tid = TID_W'(i);
      end
    end
  end

  // Decode funct into state updates and the response data word
  always_comb begin
    w_err       = 1'b0;
    w_set_asid  = 1'b0;
    w_alloc     = 1'b0;
    w_write     = 1'b0;
    w_read      = 1'b0;
    w_clear_int = 1'b0;
    w_data      = '0;
    case (io_cmd_bits_inst_funct)
      FUNCT_SET_ASID: begin
        if (io_s) w_set_asid = 1'b1;
        else      w_err      = 1'b1;
      end
      FUNCT_NEW_TID: begin
        if (w_any_free) begin
          w_alloc = 1'b1;
          w_data  = 64'({r_asid, 16'(w_free_tid)});
        end else begin
          w_err = 1'b1;
        end
      end
      FUNCT_WRITE_DATA: begin
        if (r_slot_valid[w_tid]) w_write = 1'b1;
        else                     w_err   = 1'b1;
      end
      FUNCT_READ_DATA: begin
        if (r_slot_valid[w_tid]) begin
          w_read = 1'b1;
          w_data = r_data_store[w_tid];
        end else begin
          w_err = 1'b1;
        end
      end
      FUNCT_CLEAR_INT: w_clear_int = 1'b1;
      default:         w_err       = 1'b1;
    endcase
    if (w_err) w_data = RESP_ERROR;
  end

  // ASID, slot ownership and the sticky interrupt commit at the acceptance edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_asid       <= '0;
      r_slot_valid <= '0;
      r_interrupt  <= 1'b0;
    end else if (w_accept) begin
      if (w_set_asid) r_asid <= io_cmd_bits_rs1[ASID_W-1:0];
      if (w_alloc)    r_slot_valid[w_free_tid] <= 1'b1;
      if (w_read)     r_slot_valid[w_tid] <= 1'b0;
      if (w_err)            r_interrupt <= 1'b1;
      else if (w_clear_int) r_interrupt <= 1'b0;
    end
  end

  // Per-slot data words; a fresh allocation starts from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TIDS; i++) r_data_store[i] <= '0;
    end else if (w_accept) begin
      if (w_alloc) r_data_store[w_free_tid] <= '0;
      if (w_write) r_data_store[w_tid] <= io_cmd_bits_rs2;
    end
  end

endmodule

// File: tb/tb_rocc_cmd_responder.sv
// tb/tb_rocc_cmd_responder.sv - self-checking bench for rocc_cmd_responder
`timescale 1ns/1ps
module tb_rocc_cmd_responder;
  import dana_rocc_pkg::*;

  localparam int NUM_TIDS   = 4;
  localparam int RESP_DEPTH = 2;
  localparam int ASID_W     = 16;
  localparam int TW         = $clog2(NUM_TIDS);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  funct = '0;
  logic        xd = 1'b0;
  logic [4:0]  rd = '0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        busy;
  logic        s = 1'b1;
  logic        intr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rocc_cmd_responder_if resp_bus ();
  assign resp_bus.valid = resp_valid;
  assign resp_bus.ready = resp_ready;
  assign resp_bus.bits  = {resp_rd, resp_data};

  rocc_cmd_responder #(
    .NUM_TIDS   (NUM_TIDS),
    .RESP_DEPTH (RESP_DEPTH),
    .ASID_W     (ASID_W)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .io_cmd_valid            (cmd_valid),
    .io_cmd_ready            (cmd_ready),
    .io_cmd_bits_inst_funct  (funct),
    .io_cmd_bits_inst_rs2    (5'd2),
    .io_cmd_bits_inst_rs1    (5'd1),
    .io_cmd_bits_inst_xd     (xd),
    .io_cmd_bits_inst_xs1    (1'b1),
    .io_cmd_bits_inst_xs2    (1'b0),
    .io_cmd_bits_inst_rd     (rd),
    .io_cmd_bits_inst_opcode (7'h0B),
    .io_cmd_bits_rs1         (rs1),
    .io_cmd_bits_rs2         (rs2),
    .io_resp_valid           (resp_valid),
    .io_resp_ready           (resp_ready),
    .io_resp_bits_rd         (resp_rd),
    .io_resp_bits_data       (resp_data),
    .io_busy                 (busy),
    .io_s                    (s),
    .io_interrupt            (intr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending responses, ASID, slot ownership, slot data, interrupt
  logic [68:0]       mq[$];
  logic [ASID_W-1:0] m_asid = '0;
  bit                m_valid [NUM_TIDS];
  logic [63:0]       m_store [NUM_TIDS];
  bit                m_int = 1'b0;

  function automatic int lowest_free();
    for (int i = 0; i < NUM_TIDS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  initial begin
    foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_store[i] = '0; end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_asid = '0;
        m_int  = 1'b0;
        foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_store[i] = '0; end
      end else begin
        bit acc, pop, err;
        int t, f;
        logic [63:0] d;
        acc = cmd_valid && (mq.size() < RESP_DEPTH);
        pop = resp_bus.ready && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (acc) begin
          err = 1'b0;
          d   = '0;
          t   = int'(rs1[TW-1:0]);
          case (funct)
            7'd0: if (s) m_asid = rs1[ASID_W-1:0]; else err = 1'b1;
            7'd1: begin
              f = lowest_free();
              if (f < 0) err = 1'b1;
              else begin
                m_valid[f] = 1'b1;
                m_store[f] = '0;
                d = (64'(m_asid) << 16) + 64'(f);
              end
            end
            7'd2: if (m_valid[t]) m_store[t] = rs2; else err = 1'b1;
            7'd3: if (m_valid[t]) begin d = m_store[t]; m_valid[t] = 1'b0; end else err = 1'b1;
            7'd4: m_int = 1'b0;
            default: err = 1'b1;
          endcase
          if (err) begin m_int = 1'b1; d = '1; end
          if (xd) mq.push_back({rd, d});
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model, sampled away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [68:0] fr;
        chk("m_cmd_ready", cmd_ready, (!reset && mq.size() < RESP_DEPTH));
        chk("m_resp_valid", resp_bus.valid, (mq.size() != 0));
        chk("m_busy", busy, (mq.size() != 0));
        chk("m_interrupt", intr, m_int);
        if (mq.size() != 0) begin
          fr = mq[0];
          chk("m_resp_rd", resp_bus.bits.rd, fr[68:64]);
          chk("m_resp_data", resp_bus.bits.data, fr[63:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_cmd(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                           input logic x, input logic [4:0] r);
    funct = f; rs1 = a; rs2 = b; xd = x; rd = r; cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name, output int iters);
    bit r, done;
    done  = 1'b0;
    iters = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      r = cmd_ready;
      @(posedge clk);
      #2;
      iters++;
      if (r) done = 1'b1;
    end
    cmd_valid = 1'b0;
    chk({name, "_accepted"}, done, 1'b1);
  endtask

  task automatic cmd(input string name, input logic [6:0] f, input logic [63:0] a,
                     input logic [63:0] b, input logic x, input logic [4:0] r);
    int it;
    start_cmd(f, a, b, x, r);
    wait_accept(name, it);
  endtask

  task automatic expect_resp(input string name, input logic [4:0] r, input logic [63:0] d);
    chk({name, "_valid"}, resp_bus.valid, 1'b1);
    chk({name, "_rd"}, resp_bus.bits.rd, r);
    chk({name, "_data"}, resp_bus.bits.data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int it;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_interrupt", intr, 1'b0);
    chk("rst_resp_rd", resp_rd, 5'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    cmd("set_asid", 7'd0, 64'h1234, 64'h0, 1'b1, 5'd5);
    expect_resp("set_asid", 5'd5, 64'h0);
    cmd("new_tid0", 7'd1, 64'h0, 64'h0, 1'b1, 5'd6);
    expect_resp("new_tid0", 5'd6, 64'h0000_0000_1234_0000);

    cmd("write0", 7'd2, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 5'd0);
    chk("write0_no_resp", resp_valid, 1'b0);
    cmd("read0", 7'd3, 64'h0, 64'h0, 1'b1, 5'd7);
    expect_resp("read0", 5'd7, 64'hDEAD_BEEF_CAFE_F00D);
    cmd("realloc0", 7'd1, 64'h0, 64'h0, 1'b1, 5'd8);
    expect_resp("realloc0", 5'd8, 64'h0000_0000_1234_0000);

    cmd("new_tid1", 7'd1, 64'h0, 64'h0, 1'b1, 5'd8);
    expect_resp("new_tid1", 5'd8, 64'h0000_0000_1234_0001);
    cmd("new_tid2", 7'd1, 64'h0, 64'h0, 1'b1, 5'd8);
    expect_resp("new_tid2", 5'd8, 64'h0000_0000_1234_0002);
    cmd("new_tid3", 7'd1, 64'h0, 64'h0, 1'b1, 5'd8);
    expect_resp("new_tid3", 5'd8, 64'h0000_0000_1234_0003);
    chk("alloc_no_int", intr, 1'b0);
    cmd("exhaust", 7'd1, 64'h0, 64'h0, 1'b1, 5'd8);
    expect_resp("exhaust", 5'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("exhaust_int", intr, 1'b1);
    cmd("clear_int", 7'd4, 64'h0, 64'h0, 1'b1, 5'd9);
    expect_resp("clear_int", 5'd9, 64'h0);
    chk("clear_int_int", intr, 1'b0);

    cmd("write2", 7'd2, 64'h2, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd10);
    expect_resp("write2", 5'd10, 64'h0);
    cmd("read2", 7'd3, 64'h2, 64'h0, 1'b1, 5'd11);
    expect_resp("read2", 5'd11, 64'h0123_4567_89AB_CDEF);
    cmd("reread2", 7'd3, 64'h2, 64'h0, 1'b1, 5'd11);
    expect_resp("reread2", 5'd11, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("reread2_int", intr, 1'b1);
    cmd("clear_int2", 7'd4, 64'h0, 64'h0, 1'b0, 5'd0);
    chk("clear_int2_int", intr, 1'b0);
    chk("clear_int2_no_resp", resp_valid, 1'b0);

    s = 1'b0;
    cmd("user_set_asid", 7'd0, 64'hBEEF, 64'h0, 1'b1, 5'd12);
    expect_resp("user_set_asid", 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("user_set_asid_int", intr, 1'b1);
    s = 1'b1;
    cmd("read1", 7'd3, 64'h1, 64'h0, 1'b1, 5'd13);
    expect_resp("read1", 5'd13, 64'h0);
    cmd("asid_kept", 7'd1, 64'h0, 64'h0, 1'b1, 5'd14);
    expect_resp("asid_kept", 5'd14, 64'h0000_0000_1234_0001);
    cmd("clear_int3", 7'd4, 64'h0, 64'h0, 1'b0, 5'd0);
    chk("clear_int3_int", intr, 1'b0);
    cmd("funct9", 7'd9, 64'h0, 64'h0, 1'b0, 5'd0);
    chk("funct9_no_resp", resp_valid, 1'b0);
    chk("funct9_int", intr, 1'b1);
    cmd("clear_int4", 7'd4, 64'h0, 64'h0, 1'b0, 5'd0);

    cmd("write3", 7'd2, 64'h3, 64'hA5A5_0000_5A5A_FFFF, 1'b0, 5'd0);
    cmd("write0b", 7'd2, 64'h0, 64'h1111_2222_3333_4444, 1'b0, 5'd0);

    resp_ready = 1'b0;
    cmd("bp_a", 7'd3, 64'h3, 64'h0, 1'b1, 5'd20);
    cmd("bp_b", 7'd3, 64'h0, 64'h0, 1'b1, 5'd21);
    start_cmd(7'd1, 64'h0, 64'h0, 1'b1, 5'd22);
    chk("bp_full_ready", cmd_ready, 1'b0);
    chk("bp_full_busy", busy, 1'b1);
    expect_resp("bp_hold0", 5'd20, 64'hA5A5_0000_5A5A_FFFF);
    tick(2);
    expect_resp("bp_hold2", 5'd20, 64'hA5A5_0000_5A5A_FFFF);
    chk("bp_still_full", cmd_ready, 1'b0);
    resp_ready = 1'b1;
    tick(1);
    expect_resp("bp_drain_b", 5'd21, 64'h1111_2222_3333_4444);
    wait_accept("bp_c", it);
    chk("bp_c_latency", 64'(it), 64'd1);
    expect_resp("bp_c", 5'd22, 64'h0000_0000_1234_0000);
    tick(1);
    chk("bp_drained", resp_valid, 1'b0);

    resp_ready = 1'b0;
    cmd("mid_a", 7'd4, 64'h0, 64'h0, 1'b1, 5'd16);
    cmd("mid_b", 7'd4, 64'h0, 64'h0, 1'b1, 5'd17);
    resp_ready = 1'b1;
    tick(1);
    expect_resp("mid_b", 5'd17, 64'h0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", resp_valid, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    tick(2);
    reset = 1'b0;
    #1;
    chk("mid_rst_release_ready", cmd_ready, 1'b1);
    cmd("after_rst_tid", 7'd1, 64'h0, 64'h0, 1'b1, 5'd3);
    expect_resp("after_rst_tid", 5'd3, 64'h0);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
